vadd_issue_seq: RTL and testbench

// Issue sequencer for the vAdd/min-max ALU pipeline. Takes one vector add-class command
// (vl, sew, opSel, dest address), splits it into DATA_WIDTH beats and drives the ALU

---
 rtl/vadd_issue_seq.sv | 291 +++++++++++++++++++++++++++++
 tb/tb_vadd_issue_seq.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/vadd_issue_seq.sv
// vadd_issue_seq
// Issue sequencer for the vAdd/min-max ALU pipeline. Accepts one add-class vector
// command, splits it into DATA_WIDTH-wide beats and drives the ALU request port.
// It signals done once the last beat has left the fixed-latency ALU pipe.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   cmd_valid/ready     command handshake (ready only while idle)
//   cmd_vl/sew/opsel    element count, element width (8 << sew), ALU opSel
//   cmd_addr            destination base byte address (BE_WIDTH aligned)
//   stall               hold issue for this cycle (operand not available)
//   alu_*               registered ALU request: valid, addr, byte enables, start index,
//                       first/last beat flags, latched opsel and sew
//   busy                sequencer not idle
//   done / err          one-cycle completion pulse / illegal-sew pulse (with done)
module vadd_issue_seq #(
  parameter int DATA_WIDTH    = 64,
  parameter int BE_WIDTH      = DATA_WIDTH / 8,
  parameter int ADDR_WIDTH    = 32,
  parameter int VL_WIDTH      = 16,
  parameter int OPSEL_WIDTH   = 9,
  parameter int PIPE_LAT      = 6,
  parameter int ENABLE_64_BIT = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [VL_WIDTH-1:0]    cmd_vl,
  input  logic [1:0]             cmd_sew,
  input  logic [OPSEL_WIDTH-1:0] cmd_opsel,
  input  logic [ADDR_WIDTH-1:0]  cmd_addr,
  input  logic                   stall,
  output logic                   alu_valid,
  output logic [ADDR_WIDTH-1:0]  alu_addr,
  output logic [BE_WIDTH-1:0]    alu_be,
  output logic [5:0]             alu_start_idx,
  output logic                   alu_req_start,
  output logic                   alu_req_end,
  output logic [OPSEL_WIDTH-1:0] alu_opsel,
  output logic [1:0]             alu_sew,
  output logic                   busy,
  output logic                   done,
  output logic                   err
);

  localparam int BE_SHIFT = $clog2(BE_WIDTH);
  localparam int CNT_W    = $clog2(PIPE_LAT + 2);
  localparam logic [CNT_W-1:0]    CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]    CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [VL_WIDTH-1:0] VL_ZERO  = {VL_WIDTH{1'b0}};
  localparam logic [VL_WIDTH-1:0] VL_ONE   = {{(VL_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [BE_WIDTH:0]   BE_ONE   = {{BE_WIDTH{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t state_r, state_nxt_s;

  // latched command
  logic [VL_WIDTH-1:0]    vl_r;
  logic [1:0]             sew_r;
  logic [OPSEL_WIDTH-1:0] opsel_r;
  logic [ADDR_WIDTH-1:0]  base_r;
  logic [VL_WIDTH-1:0]    beat_r;
  logic [CNT_W-1:0]       drain_r;

  // command classification
  logic accept_s, sew_bad_s, skip_s;

  // per-beat datapath
  logic [VL_WIDTH-1:0]   epb_s, elem0_s, rem_s;
  logic                  last_s, mask_op_s;
  logic [VL_WIDTH+2:0]   nbytes_s;
  logic [BE_WIDTH:0]     be_mask_s;
  logic [BE_WIDTH-1:0]   be_beat_s;
  logic [ADDR_WIDTH-1:0] line_idx_s, addr_beat_s;
  logic [5:0]            sidx_beat_s;

  // next values of the registered outputs
  logic                   cmd_ready_nxt_s, busy_nxt_s, done_nxt_s, err_nxt_s;
  logic                   alu_valid_nxt_s, alu_req_start_nxt_s, alu_req_end_nxt_s;
  logic [ADDR_WIDTH-1:0]  alu_addr_nxt_s;
  logic [BE_WIDTH-1:0]    alu_be_nxt_s;
  logic [5:0]             alu_start_idx_nxt_s;
  logic [OPSEL_WIDTH-1:0] alu_opsel_nxt_s;
  logic [1:0]             alu_sew_nxt_s;

  assign accept_s  = cmd_valid & cmd_ready;
  // sew=3 needs both the 64-bit option and a 64-bit datapath
  assign sew_bad_s = (cmd_sew == 2'd3) && ((ENABLE_64_BIT == 0) || (DATA_WIDTH < 64));
  assign skip_s    = (cmd_vl == VL_ZERO) || sew_bad_s;

  // Beat geometry: elements per beat, first element, remaining count, byte enables, address
  always_comb begin
    epb_s     = VL_WIDTH'(BE_WIDTH) >> sew_r;
    elem0_s   = beat_r * epb_s;
    rem_s     = vl_r - elem0_s;
    last_s    = (rem_s <= epb_s);
    mask_op_s = opsel_r[OPSEL_WIDTH-1];
    nbytes_s  = {3'b000, rem_s} << sew_r;
    // low nbytes ones; only meaningful on the last beat where nbytes <= BE_WIDTH
    be_mask_s = (BE_ONE << nbytes_s) - BE_ONE;
    if (last_s) begin
      be_beat_s = be_mask_s[BE_WIDTH-1:0];
    end else begin
      be_beat_s = {BE_WIDTH{1'b1}};
    end
    // mask results pack one bit per element, so 64 elements share one destination beat
    if (mask_op_s) begin
      line_idx_s  = ADDR_WIDTH'(elem0_s >> 3'd6);
      sidx_beat_s = elem0_s[5:0];
    end else begin
      line_idx_s  = ADDR_WIDTH'(beat_r);
      sidx_beat_s = 6'd0;
    end
    addr_beat_s = base_r + (line_idx_s << BE_SHIFT);
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s && !skip_s) begin
          state_nxt_s = ISSUE;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      ISSUE: begin
        if (!stall && last_s) begin
          state_nxt_s = DRAIN;
        end else begin
          state_nxt_s = ISSUE;
        end
      end
      DRAIN: begin
        if (drain_r == CNT_ZERO) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = DRAIN;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Output logic: next values for the registered outputs
  always_comb begin
    alu_valid_nxt_s     = 1'b0;
    alu_addr_nxt_s      = {ADDR_WIDTH{1'b0}};
    alu_be_nxt_s        = {BE_WIDTH{1'b0}};
    alu_start_idx_nxt_s = 6'd0;
    alu_req_start_nxt_s = 1'b0;
    alu_req_end_nxt_s   = 1'b0;
    alu_opsel_nxt_s     = {OPSEL_WIDTH{1'b0}};
    alu_sew_nxt_s       = 2'd0;
    done_nxt_s          = 1'b0;
    err_nxt_s           = 1'b0;
    case (state_r)
      IDLE: begin
        // degenerate commands complete without issuing anything
        if (accept_s && skip_s) begin
          done_nxt_s = 1'b1;
          err_nxt_s  = sew_bad_s;
        end else begin
          done_nxt_s = 1'b0;
          err_nxt_s  = 1'b0;
        end
      end
      ISSUE: begin
        if (stall) begin
          // keep the request fields so the held beat reissues unchanged
          alu_addr_nxt_s      = alu_addr;
          alu_be_nxt_s        = alu_be;
          alu_start_idx_nxt_s = alu_start_idx;
          alu_req_start_nxt_s = alu_req_start;
          alu_req_end_nxt_s   = alu_req_end;
          alu_opsel_nxt_s     = alu_opsel;
          alu_sew_nxt_s       = alu_sew;
        end else begin
          alu_valid_nxt_s     = 1'b1;
          alu_addr_nxt_s      = addr_beat_s;
          alu_be_nxt_s        = be_beat_s;
          alu_start_idx_nxt_s = sidx_beat_s;
          alu_req_start_nxt_s = (beat_r == VL_ZERO);
          alu_req_end_nxt_s   = last_s;
          alu_opsel_nxt_s     = opsel_r;
          alu_sew_nxt_s       = sew_r;
        end
      end
      DRAIN: begin
        if (drain_r == CNT_ZERO) begin
          done_nxt_s = 1'b1;
        end else begin
          done_nxt_s = 1'b0;
        end
      end
      default: begin
        done_nxt_s = 1'b0;
      end
    endcase
    cmd_ready_nxt_s = (state_nxt_s == IDLE);
    busy_nxt_s      = (state_nxt_s != IDLE);
  end

  // Command latch, beat counter and drain counter
  always_ff @(posedge clk) begin
    if (rst) begin
      vl_r    <= VL_ZERO;
      sew_r   <= 2'd0;
      opsel_r <= {OPSEL_WIDTH{1'b0}};
      base_r  <= {ADDR_WIDTH{1'b0}};
      beat_r  <= VL_ZERO;
      drain_r <= CNT_ZERO;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            vl_r    <= cmd_vl;
            sew_r   <= cmd_sew;
            opsel_r <= cmd_opsel;
            base_r  <= cmd_addr;
            beat_r  <= VL_ZERO;
          end
        end
        ISSUE: begin
          if (!stall) begin
            beat_r <= beat_r + VL_ONE;
            if (last_s) begin
              drain_r <= CNT_W'(PIPE_LAT);
            end
          end
        end
        DRAIN: begin
          if (drain_r != CNT_ZERO) begin
            drain_r <= drain_r - CNT_ONE;
          end
        end
        default: begin
          beat_r <= VL_ZERO;
        end
      endcase
    end
  end

  // Registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_ready     <= 1'b1;
      busy          <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
      alu_valid     <= 1'b0;
      alu_addr      <= {ADDR_WIDTH{1'b0}};
      alu_be        <= {BE_WIDTH{1'b0}};
      alu_start_idx <= 6'd0;
      alu_req_start <= 1'b0;
      alu_req_end   <= 1'b0;
      alu_opsel     <= {OPSEL_WIDTH{1'b0}};
      alu_sew       <= 2'd0;
    end else begin
      cmd_ready     <= cmd_ready_nxt_s;
      busy          <= busy_nxt_s;
      done          <= done_nxt_s;
      err           <= err_nxt_s;
      alu_valid     <= alu_valid_nxt_s;
      alu_addr      <= alu_addr_nxt_s;
      alu_be        <= alu_be_nxt_s;
      alu_start_idx <= alu_start_idx_nxt_s;
      alu_req_start <= alu_req_start_nxt_s;
      alu_req_end   <= alu_req_end_nxt_s;
      alu_opsel     <= alu_opsel_nxt_s;
      alu_sew       <= alu_sew_nxt_s;
    end
  end

endmodule

// File: tb/tb_vadd_issue_seq.sv
// tb_vadd_issue_seq
// Directed bench for vadd_issue_seq (DATA_WIDTH=64, PIPE_LAT=6, ENABLE_64_BIT=0).
// Each command is offered, its beats are logged, and the log is compared with
// hand-computed beat tables.
module tb_vadd_issue_seq;

  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [15:0]   cmd_vl;
  logic [1:0]    cmd_sew;
  logic [8:0]    cmd_opsel;
  logic [AW-1:0] cmd_addr;
  logic          stall;
  logic          alu_valid;
  logic [AW-1:0] alu_addr;
  logic [7:0]    alu_be;
  logic [5:0]    alu_start_idx;
  logic          alu_req_start;
  logic          alu_req_end;
  logic [8:0]    alu_opsel;
  logic [1:0]    alu_sew;
  logic          busy;
  logic          done;
  logic          err;

  vadd_issue_seq #(
    .DATA_WIDTH(64), .ADDR_WIDTH(32), .VL_WIDTH(16), .OPSEL_WIDTH(9),
    .PIPE_LAT(6), .ENABLE_64_BIT(0)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_vl(cmd_vl),
    .cmd_sew(cmd_sew), .cmd_opsel(cmd_opsel), .cmd_addr(cmd_addr),
    .stall(stall),
    .alu_valid(alu_valid), .alu_addr(alu_addr), .alu_be(alu_be),
    .alu_start_idx(alu_start_idx), .alu_req_start(alu_req_start),
    .alu_req_end(alu_req_end), .alu_opsel(alu_opsel), .alu_sew(alu_sew),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int n_run  = 0;
  int n_fail = 0;

  // beat log of the most recent command
  logic [AW-1:0] b_addr [8];
  logic [7:0]    b_be   [8];
  logic [5:0]    b_sidx [8];
  logic          b_rs   [8];
  logic          b_re   [8];
  logic [8:0]    b_op   [8];
  int            b_cyc  [8];
  int            nb;
  int            done_cyc;
  logic          err_seen;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one command, log its beats until done (bounded), optionally stalling
  // for stall_len cycles once stall_beat beats have been issued.
  task automatic run_cmd(input logic [15:0] vl, input logic [1:0] sew, input logic [8:0] op,
                         input logic [AW-1:0] addr, input int stall_beat, input int stall_len);
    int   stalled;
    logic stall_prev;
    bit   got_done;
    nb = 0; done_cyc = -1; err_seen = 1'b0;
    stalled = 0; stall_prev = 1'b0; got_done = 1'b0;
    check_eq("ready_before_cmd", {63'd0, cmd_ready}, 64'd1);
    cmd_valid = 1'b1; cmd_vl = vl; cmd_sew = sew; cmd_opsel = op; cmd_addr = addr;
    tick();
    cmd_valid = 1'b0; cmd_vl = 16'd0; cmd_sew = 2'd0; cmd_opsel = 9'd0; cmd_addr = '0;
    for (int cyc = 1; cyc <= 200; cyc++) begin
      if (stall_prev) begin
        check_eq("stall_valid_low", {63'd0, alu_valid}, 64'd0);
        if (nb > 0) check_eq("stall_addr_hold", {32'd0, alu_addr}, {32'd0, b_addr[nb-1]});
      end
      if (alu_valid && nb < 8) begin
        b_addr[nb] = alu_addr; b_be[nb] = alu_be; b_sidx[nb] = alu_start_idx;
        b_rs[nb] = alu_req_start; b_re[nb] = alu_req_end; b_op[nb] = alu_opsel;
        b_cyc[nb] = cyc;
        nb++;
      end
      if (done) begin
        got_done = 1'b1; done_cyc = cyc; err_seen = err;
        check_eq("done_cmd_ready", {63'd0, cmd_ready}, 64'd1);
        check_eq("done_busy_low", {63'd0, busy}, 64'd0);
        check_eq("done_valid_low", {63'd0, alu_valid}, 64'd0);
        break;
      end
      if (nb == stall_beat && stalled < stall_len) begin
        stall = 1'b1; stalled++;
      end else begin
        stall = 1'b0;
      end
      stall_prev = stall;
      tick();
    end
    stall = 1'b0;
    if (!got_done) check_eq("done_timeout", 64'd0, 64'd1);
  endtask

  // compare logged beat i against expected fields
  task automatic check_beat(input string tag, input int i, input logic [AW-1:0] ea,
                            input logic [7:0] ebe, input logic [5:0] esi,
                            input logic ers, input logic ere);
    check_eq({tag, "_addr"}, {32'd0, b_addr[i]}, {32'd0, ea});
    check_eq({tag, "_be"},   {56'd0, b_be[i]},   {56'd0, ebe});
    check_eq({tag, "_sidx"}, {58'd0, b_sidx[i]}, {58'd0, esi});
    check_eq({tag, "_rs"},   {63'd0, b_rs[i]},   {63'd0, ers});
    check_eq({tag, "_re"},   {63'd0, b_re[i]},   {63'd0, ere});
  endtask

  task automatic test_basic(input string tag);
    run_cmd(16'd20, 2'd0, 9'h012, 32'h100, -1, 0);
    check_eq({tag, "_nbeats"}, 64'(nb), 64'd3);
    check_beat({tag, "_b0"}, 0, 32'h100, 8'hFF, 6'd0, 1'b1, 1'b0);
    check_beat({tag, "_b1"}, 1, 32'h108, 8'hFF, 6'd0, 1'b0, 1'b0);
    check_beat({tag, "_b2"}, 2, 32'h110, 8'h0F, 6'd0, 1'b0, 1'b1);
    check_eq({tag, "_opsel"}, {55'd0, b_op[0]}, 64'h012);
    check_eq({tag, "_done_gap"}, 64'(done_cyc - b_cyc[2]), 64'd7);
    check_eq({tag, "_err"}, {63'd0, err_seen}, 64'd0);
  endtask

  initial begin
    int   seen_done, seen_valid;
    rst = 1'b1; cmd_valid = 1'b0; cmd_vl = 16'd0; cmd_sew = 2'd0;
    cmd_opsel = 9'd0; cmd_addr = '0; stall = 1'b0;
    tick(); tick();
    // reset state
    check_eq("rst_cmd_ready", {63'd0, cmd_ready}, 64'd1);
    check_eq("rst_busy", {63'd0, busy}, 64'd0);
    check_eq("rst_valid", {63'd0, alu_valid}, 64'd0);
    check_eq("rst_done", {63'd0, done}, 64'd0);
    check_eq("rst_addr", {32'd0, alu_addr}, 64'd0);
    rst = 1'b0;
    tick();

    // 1: sew=0, vl=20, three beats
    test_basic("t1");

    // 2a: sew=2, vl=3 -> two beats, FF then 0F
    run_cmd(16'd3, 2'd2, 9'h001, 32'h200, -1, 0);
    check_eq("t2a_nbeats", 64'(nb), 64'd2);
    check_beat("t2a_b0", 0, 32'h200, 8'hFF, 6'd0, 1'b1, 1'b0);
    check_beat("t2a_b1", 1, 32'h208, 8'h0F, 6'd0, 1'b0, 1'b1);

    // 2b: sew=1, vl=4 -> single full beat with start and end
    run_cmd(16'd4, 2'd1, 9'h002, 32'h240, -1, 0);
    check_eq("t2b_nbeats", 64'(nb), 64'd1);
    check_beat("t2b_b0", 0, 32'h240, 8'hFF, 6'd0, 1'b1, 1'b1);
    check_eq("t2b_done_gap", 64'(done_cyc - b_cyc[0]), 64'd7);

    // 3: mask op, sew=0, vl=20 -> same line, start_idx 0/8/16
    run_cmd(16'd20, 2'd0, 9'h100, 32'h280, -1, 0);
    check_eq("t3_nbeats", 64'(nb), 64'd3);
    check_beat("t3_b0", 0, 32'h280, 8'hFF, 6'd0,  1'b1, 1'b0);
    check_beat("t3_b1", 1, 32'h280, 8'hFF, 6'd8,  1'b0, 1'b0);
    check_beat("t3_b2", 2, 32'h280, 8'h0F, 6'd16, 1'b0, 1'b1);

    // 4: stall 3 cycles at beat1, sew=0, vl=24
    run_cmd(16'd24, 2'd0, 9'h003, 32'h300, 1, 3);
    check_eq("t4_nbeats", 64'(nb), 64'd3);
    check_eq("t4_stall_gap", 64'(b_cyc[1] - b_cyc[0]), 64'd4);
    check_beat("t4_b1", 1, 32'h308, 8'hFF, 6'd0, 1'b0, 1'b0);
    check_beat("t4_b2", 2, 32'h310, 8'hFF, 6'd0, 1'b0, 1'b1);
    check_eq("t4_done_gap", 64'(done_cyc - b_cyc[2]), 64'd7);

    // 5a: vl=0 -> done next cycle, no beats, no err
    run_cmd(16'd0, 2'd0, 9'h000, 32'h400, -1, 0);
    check_eq("t5a_nbeats", 64'(nb), 64'd0);
    check_eq("t5a_done_cyc", 64'(done_cyc), 64'd1);
    check_eq("t5a_err", {63'd0, err_seen}, 64'd0);

    // 5b: sew=3 with 64-bit disabled -> done+err, no beats
    run_cmd(16'd5, 2'd3, 9'h000, 32'h440, -1, 0);
    check_eq("t5b_nbeats", 64'(nb), 64'd0);
    check_eq("t5b_done_cyc", 64'(done_cyc), 64'd1);
    check_eq("t5b_err", {63'd0, err_seen}, 64'd1);

    // 6: reset during ISSUE aborts with no done
    tick();
    cmd_valid = 1'b1; cmd_vl = 16'd40; cmd_sew = 2'd0; cmd_opsel = 9'h005; cmd_addr = 32'h500;
    tick();
    cmd_valid = 1'b0;
    tick(); tick();
    check_eq("t6_mid_valid", {63'd0, alu_valid}, 64'd1);
    check_eq("t6_mid_addr", {32'd0, alu_addr}, 64'h508);
    rst = 1'b1;
    tick();
    check_eq("t6_rst_valid", {63'd0, alu_valid}, 64'd0);
    check_eq("t6_rst_addr", {32'd0, alu_addr}, 64'd0);
    check_eq("t6_rst_be", {56'd0, alu_be}, 64'd0);
    check_eq("t6_rst_opsel", {55'd0, alu_opsel}, 64'd0);
    check_eq("t6_rst_busy", {63'd0, busy}, 64'd0);
    check_eq("t6_rst_done", {63'd0, done}, 64'd0);
    check_eq("t6_rst_ready", {63'd0, cmd_ready}, 64'd1);
    rst = 1'b0;
    seen_done = 0; seen_valid = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done) seen_done++;
      if (alu_valid) seen_valid++;
    end
    check_eq("t6_no_done", 64'(seen_done), 64'd0);
    check_eq("t6_no_valid", 64'(seen_valid), 64'd0);
    test_basic("t6_after");

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
